// File: rtl/rv32_pkg.sv
// Shared RV32 pipeline definitions: datapath width, writeback source
// selectors, load funct3 encodings and the register index type.
package rv32_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MEM = 2'b01;
  localparam logic [1:0] WB_SEL_PC4 = 2'b10;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;

  typedef logic [4:0] reg_idx_t;

endpackage

// File: rtl/mem_wb_stage_if.sv
// MEM/WB boundary bundle: incoming memory-stage result plus the
// register-file write port, forwarding outputs and retire counter.
interface mem_wb_stage_if;
  import rv32_pkg::*;

  logic            STALL;
  logic            FLUSH;
  logic            IN_VALID;
  logic            IN_REG_WRITE;
  reg_idx_t        IN_RD;
  logic [1:0]      IN_WB_SEL;
  logic [2:0]      IN_FUNCT3;
  logic [XLEN-1:0] IN_ALU_RESULT;
  logic [XLEN-1:0] IN_MEM_RDATA;
  logic [XLEN-1:0] IN_PC_PLUS4;

  logic            WB_WRITE_ENABLE;
  reg_idx_t        WB_WRITE_REG;
  logic [XLEN-1:0] WB_WRITE_DATA;
  logic            LOAD_MISALIGNED;
  logic [63:0]     INSTRET;

  modport master (
    output STALL, FLUSH, IN_VALID, IN_REG_WRITE, IN_RD, IN_WB_SEL, IN_FUNCT3,
           IN_ALU_RESULT, IN_MEM_RDATA, IN_PC_PLUS4,
    input  WB_WRITE_ENABLE, WB_WRITE_REG, WB_WRITE_DATA, LOAD_MISALIGNED, INSTRET
  );

  modport slave (
    input  STALL, FLUSH, IN_VALID, IN_REG_WRITE, IN_RD, IN_WB_SEL, IN_FUNCT3,
           IN_ALU_RESULT, IN_MEM_RDATA, IN_PC_PLUS4,
    output WB_WRITE_ENABLE, WB_WRITE_REG, WB_WRITE_DATA, LOAD_MISALIGNED, INSTRET
  );

endinterface

// File: rtl/load_formatter.sv
// Combinational load lane extraction and sign/zero extension, plus a
// misalignment flag for the requested access width.
module load_formatter
  import rv32_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      addr,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data,
  output logic            misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[{addr, 3'b000} +: 8];
  assign half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

  // Unlisted funct3 encodings fall through to word behaviour, including its alignment rule.
  always_comb begin
    data       = rdata;
    misaligned = (addr != 2'b00);
    case (funct3)
      FUNCT3_LB: begin
        data       = {{24{byte_sel[7]}}, byte_sel};
        misaligned = 1'b0;
      end
      FUNCT3_LBU: begin
        data       = {24'b0, byte_sel};
        misaligned = 1'b0;
      end
      FUNCT3_LH: begin
        data       = {{16{half_sel[15]}}, half_sel};
        misaligned = addr[0];
      end
      FUNCT3_LHU: begin
        data       = {16'b0, half_sel};
        misaligned = addr[0];
      end
      default: begin
        data       = rdata;
        misaligned = (addr != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline slot: formats the writeback value, drives the register
// file write port and counts instructions as they leave the stage.
module mem_wb_stage
  import rv32_pkg::*;
(
  input  logic           CLK,
  input  logic           RST,
  mem_wb_stage_if.slave  bus
);

  logic            slot_valid;
  logic            slot_regwrite;
  reg_idx_t        slot_rd;
  logic [XLEN-1:0] slot_data;
  logic            slot_misaligned;
  logic [63:0]     instret;

  logic [XLEN-1:0] load_data;
  logic            load_misaligned_raw;
  logic            in_is_load;
  logic            in_misaligned;
  logic [XLEN-1:0] next_data;
  logic            retire;

  load_formatter u_load_formatter (
    .rdata      (bus.IN_MEM_RDATA),
    .addr       (bus.IN_ALU_RESULT[1:0]),
    .funct3     (bus.IN_FUNCT3),
    .data       (load_data),
    .misaligned (load_misaligned_raw)
  );

  assign in_is_load    = (bus.IN_WB_SEL == WB_SEL_MEM);
  assign in_misaligned = in_is_load & load_misaligned_raw;

  // The reserved selector 11 behaves as an ALU writeback.
  always_comb begin
    next_data = bus.IN_ALU_RESULT;
    case (bus.IN_WB_SEL)
      WB_SEL_MEM: next_data = load_data;
      WB_SEL_PC4: next_data = bus.IN_PC_PLUS4;
      default:    next_data = bus.IN_ALU_RESULT;
    endcase
  end

  // An instruction retires on the edge it leaves; flushed, stalled or faulting slots do not.
  assign retire = slot_valid & ~bus.STALL & ~bus.FLUSH & ~slot_misaligned;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      slot_valid      <= 1'b0;
      slot_regwrite   <= 1'b0;
      slot_rd         <= '0;
      slot_data       <= '0;
      slot_misaligned <= 1'b0;
    end else if (bus.FLUSH) begin
      slot_valid      <= 1'b0;
      slot_regwrite   <= 1'b0;
      slot_rd         <= '0;
      slot_data       <= '0;
      slot_misaligned <= 1'b0;
    end else if (!bus.STALL) begin
      slot_valid      <= bus.IN_VALID;
      slot_regwrite   <= bus.IN_REG_WRITE & ~in_misaligned;
      slot_rd         <= bus.IN_RD;
      slot_data       <= next_data;
      slot_misaligned <= in_misaligned;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      instret <= '0;
    end else if (retire) begin
      instret <= instret + 64'd1;
    end
  end

  assign bus.WB_WRITE_ENABLE = slot_valid & slot_regwrite & (slot_rd != '0);
  assign bus.WB_WRITE_REG    = slot_rd;
  assign bus.WB_WRITE_DATA   = slot_data;
  assign bus.LOAD_MISALIGNED = slot_valid & slot_misaligned;
  assign bus.INSTRET         = instret;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: hand-computed writeback, load formatting,
// stall/flush and retire-count expectations.
module tb_mem_wb_stage;
  import rv32_pkg::*;

  logic CLK;
  logic RST;
  int   totalChecks;
  int   passedChecks;

  mem_wb_stage_if bus ();

  mem_wb_stage dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    totalChecks++;
    if (observed === expected) passedChecks++;
    else $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
  endtask

  // Drives one cycle of inputs, takes the rising edge, then settles 1ns past it.
  task automatic applyStimulus(input logic valid, input logic regwrite,
                               input logic [4:0] rd, input logic [1:0] wbSel,
                               input logic [2:0] funct3, input logic [31:0] alu,
                               input logic [31:0] rdata, input logic [31:0] pc4,
                               input logic stall, input logic flush);
    bus.IN_VALID      = valid;
    bus.IN_REG_WRITE  = regwrite;
    bus.IN_RD         = rd;
    bus.IN_WB_SEL     = wbSel;
    bus.IN_FUNCT3     = funct3;
    bus.IN_ALU_RESULT = alu;
    bus.IN_MEM_RDATA  = rdata;
    bus.IN_PC_PLUS4   = pc4;
    bus.STALL         = stall;
    bus.FLUSH         = flush;
    @(posedge CLK);
    #1;
  endtask

  task automatic checkSlot(input string tag, input logic we, input logic [4:0] rd,
                           input logic [31:0] data, input logic mis, input logic [63:0] cnt);
    checkOutput({tag, ".we"},   {63'b0, bus.WB_WRITE_ENABLE}, {63'b0, we});
    checkOutput({tag, ".reg"},  {59'b0, bus.WB_WRITE_REG},    {59'b0, rd});
    checkOutput({tag, ".data"}, {32'b0, bus.WB_WRITE_DATA},   {32'b0, data});
    checkOutput({tag, ".mis"},  {63'b0, bus.LOAD_MISALIGNED}, {63'b0, mis});
    checkOutput({tag, ".cnt"},  bus.INSTRET,                  cnt);
  endtask

  localparam logic [31:0] RDATA = 32'h80FF_7F01;

  initial begin
    totalChecks  = 0;
    passedChecks = 0;
    RST = 1'b1;
    applyStimulus(1'b0, 1'b0, 5'd0, WB_SEL_ALU, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 5'd3, WB_SEL_ALU, 3'd0, 32'h1, 32'd0, 32'd0, 1'b0, 1'b0);
    checkSlot("reset", 1'b0, 5'd0, 32'h0, 1'b0, 64'd0);
    @(negedge CLK);
    RST = 1'b0;

    applyStimulus(1'b1, 1'b1, 5'd5, WB_SEL_ALU, 3'd0, 32'h1234_5678, 32'd0, 32'd0, 1'b0, 1'b0);
    checkSlot("alu", 1'b1, 5'd5, 32'h1234_5678, 1'b0, 64'd0);
    applyStimulus(1'b1, 1'b1, 5'd1, WB_SEL_MEM, FUNCT3_LB, 32'h3, RDATA, 32'd0, 1'b0, 1'b0);
    checkSlot("lb3", 1'b1, 5'd1, 32'hFFFF_FF80, 1'b0, 64'd1);
    applyStimulus(1'b1, 1'b1, 5'd1, WB_SEL_MEM, FUNCT3_LBU, 32'h3, RDATA, 32'd0, 1'b0, 1'b0);
    checkSlot("lbu3", 1'b1, 5'd1, 32'h0000_0080, 1'b0, 64'd2);
    applyStimulus(1'b1, 1'b1, 5'd1, WB_SEL_MEM, FUNCT3_LH, 32'h2, RDATA, 32'd0, 1'b0, 1'b0);
    checkSlot("lh2", 1'b1, 5'd1, 32'hFFFF_80FF, 1'b0, 64'd3);
    applyStimulus(1'b1, 1'b1, 5'd1, WB_SEL_MEM, FUNCT3_LHU, 32'h0, RDATA, 32'd0, 1'b0, 1'b0);
    checkSlot("lhu0", 1'b1, 5'd1, 32'h0000_7F01, 1'b0, 64'd4);
    applyStimulus(1'b1, 1'b1, 5'd1, WB_SEL_MEM, FUNCT3_LW, 32'h0, RDATA, 32'd0, 1'b0, 1'b0);
    checkSlot("lw0", 1'b1, 5'd1, 32'h80FF_7F01, 1'b0, 64'd5);

    applyStimulus(1'b1, 1'b1, 5'd7, WB_SEL_MEM, FUNCT3_LW, 32'h2, RDATA, 32'd0, 1'b0, 1'b0);
    checkOutput("lwmis.we",  {63'b0, bus.WB_WRITE_ENABLE}, 64'd0);
    checkOutput("lwmis.mis", {63'b0, bus.LOAD_MISALIGNED}, 64'd1);
    checkOutput("lwmis.cnt", bus.INSTRET, 64'd6);
    applyStimulus(1'b1, 1'b1, 5'd4, WB_SEL_MEM, FUNCT3_LHU, 32'h1, RDATA, 32'd0, 1'b0, 1'b0);
    checkOutput("lhumis.we",  {63'b0, bus.WB_WRITE_ENABLE}, 64'd0);
    checkOutput("lhumis.mis", {63'b0, bus.LOAD_MISALIGNED}, 64'd1);
    checkOutput("lhumis.cnt", bus.INSTRET, 64'd6);

    applyStimulus(1'b1, 1'b1, 5'd9, WB_SEL_ALU, 3'd0, 32'hCAFE_F00D, 32'd0, 32'd0, 1'b0, 1'b0);
    checkSlot("rd9", 1'b1, 5'd9, 32'hCAFE_F00D, 1'b0, 64'd6);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 5'd3, WB_SEL_ALU, 3'd0, 32'h1111_1111, 32'd0, 32'd0, 1'b1, 1'b0);
      checkSlot("stall", 1'b1, 5'd9, 32'hCAFE_F00D, 1'b0, 64'd6);
    end

    applyStimulus(1'b1, 1'b1, 5'd0, WB_SEL_ALU, 3'd0, 32'h55, 32'd0, 32'd0, 1'b0, 1'b0);
    checkSlot("x0", 1'b0, 5'd0, 32'h55, 1'b0, 64'd7);
    applyStimulus(1'b1, 1'b1, 5'd1, WB_SEL_PC4, 3'd0, 32'hDEAD, 32'd0, 32'h0000_0104, 1'b0, 1'b0);
    checkSlot("link", 1'b1, 5'd1, 32'h0000_0104, 1'b0, 64'd8);
    applyStimulus(1'b1, 1'b1, 5'd6, WB_SEL_ALU, 3'd0, 32'h66, 32'd0, 32'd0, 1'b1, 1'b1);
    checkSlot("flush", 1'b0, 5'd0, 32'h0, 1'b0, 64'd8);
    applyStimulus(1'b1, 1'b1, 5'd2, 2'b11, 3'd0, 32'h77, RDATA, 32'h88, 1'b0, 1'b0);
    checkSlot("rsvd", 1'b1, 5'd2, 32'h77, 1'b0, 64'd8);
    applyStimulus(1'b0, 1'b0, 5'd0, WB_SEL_ALU, 3'd0, 32'h0, 32'd0, 32'd0, 1'b0, 1'b0);
    checkSlot("bubble", 1'b0, 5'd0, 32'h0, 1'b0, 64'd9);

    applyStimulus(1'b1, 1'b1, 5'd5, WB_SEL_ALU, 3'd0, 32'hABCD, 32'd0, 32'd0, 1'b0, 1'b0);
    checkSlot("prerst", 1'b1, 5'd5, 32'hABCD, 1'b0, 64'd9);
    #2;
    RST = 1'b1;
    #1;
    checkSlot("midrst", 1'b0, 5'd0, 32'h0, 1'b0, 64'd0);
    @(negedge CLK);
    RST = 1'b0;
    applyStimulus(1'b0, 1'b0, 5'd0, WB_SEL_ALU, 3'd0, 32'h0, 32'd0, 32'd0, 1'b0, 1'b0);
    checkSlot("postrst", 1'b0, 5'd0, 32'h0, 1'b0, 64'd0);

    $display("%0d/%0d checks passed", passedChecks, totalChecks);
    $finish;
  end

endmodule
